// File: rtl/bundler_ctrl_pkg.sv
// rtl/bundler_ctrl_pkg.sv - shared types and defaults for the bundler sequencing controller
package bundler_ctrl_pkg;

  localparam int HVDimensionDef   = 512;
  localparam int NumItemsWidthDef = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_BINARIZE,
    ST_CAPTURE,
    ST_OUTPUT
  } bundler_ctrl_state_t;

endpackage

// File: rtl/bundler_item_counter.sv
// rtl/bundler_item_counter.sv - loadable item counter with terminal-count compare
module bundler_item_counter #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] num_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o,
  output logic             last_o
);

  logic [Width-1:0] count_q, count_d;
  logic [Width-1:0] num_q, num_d;

  // load clears the count and latches the job length; inc counts one handshake
  always_comb begin
    count_d = count_q;
    num_d   = num_q;
    if (load_i) begin
      count_d = '0;
      num_d   = num_i;
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  // count and length registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      num_q   <= '0;
    end else begin
      count_q <= count_d;
      num_q   <= num_d;
    end
  end

  assign count_o = count_q;
  // true while the next handshake is the final item of the job
  assign last_o  = (count_q == (num_q - Width'(1)));

endmodule

// File: rtl/bundler_ctrl.sv
// rtl/bundler_ctrl.sv - sequences accumulate, binarize and capture over a bundler bank
module bundler_ctrl
  import bundler_ctrl_pkg::*;
#(
  parameter int HVDimension   = HVDimensionDef,
  parameter int NumItemsWidth = NumItemsWidthDef
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [NumItemsWidth-1:0] num_items_i,
  input  logic                     abort_i,
  input  logic [HVDimension-1:0]   hv_i,
  input  logic                     hv_valid_i,
  output logic                     hv_ready_o,
  output logic [HVDimension-1:0]   bundle_bits_o,
  output logic                     bundle_valid_o,
  output logic                     bundle_clr_o,
  output logic                     bundle_binarize_o,
  input  logic [HVDimension-1:0]   bundle_lsb_i,
  output logic [HVDimension-1:0]   hv_o,
  output logic                     hv_valid_o,
  input  logic                     hv_ready_i,
  output logic                     busy_o,
  output logic [NumItemsWidth-1:0] items_o,
  output logic                     err_o
);

  bundler_ctrl_state_t state_q, state_d;
  logic [HVDimension-1:0] hv_q, hv_d;
  logic load, inc, last, capture;

  bundler_item_counter #(.Width(NumItemsWidth)) u_item_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .num_i   (num_items_i),
    .inc_i   (inc),
    .count_o (items_o),
    .last_o  (last)
  );

  // next-state and strobes; abort always yields a single clear and no other strobe
  always_comb begin
    state_d           = state_q;
    hv_ready_o        = 1'b0;
    bundle_valid_o    = 1'b0;
    bundle_clr_o      = 1'b0;
    bundle_binarize_o = 1'b0;
    hv_valid_o        = 1'b0;
    err_o             = 1'b0;
    load              = 1'b0;
    inc               = 1'b0;
    capture           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (num_items_i != '0) begin
            bundle_clr_o = 1'b1;
            load         = 1'b1;
            state_d      = ST_ACCUM;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (abort_i) begin
          bundle_clr_o = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          hv_ready_o     = 1'b1;
          bundle_valid_o = hv_valid_i;
          inc            = hv_valid_i;
          if (hv_valid_i && last) state_d = ST_BINARIZE;
        end
      end
      ST_BINARIZE: begin
        if (abort_i) begin
          bundle_clr_o = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          bundle_binarize_o = 1'b1;
          state_d           = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort_i) begin
          bundle_clr_o = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          capture = 1'b1;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (abort_i) begin
          bundle_clr_o = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          hv_valid_o = 1'b1;
          if (hv_ready_i) begin
            bundle_clr_o = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // result register loads the bank LSBs once, after binarize has settled the counters
  always_comb begin
    hv_d = hv_q;
    if (capture) hv_d = bundle_lsb_i;
  end

  // state and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hv_q    <= '0;
    end else begin
      state_q <= state_d;
      hv_q    <= hv_d;
    end
  end

  assign hv_o          = hv_q;
  assign bundle_bits_o = hv_i;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bundler_ctrl.sv
// tb/tb_bundler_ctrl.sv - self-checking bench for bundler_ctrl with a bundler bank model
module tb_bundler_ctrl;

  localparam int HV = 512;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [NW-1:0] num_items_i = '0;
  logic          abort_i = 1'b0;
  logic [HV-1:0] hv_i = '0;
  logic          hv_valid_i = 1'b0;
  logic          hv_ready_o;
  logic [HV-1:0] bundle_bits_o;
  logic          bundle_valid_o, bundle_clr_o, bundle_binarize_o;
  logic [HV-1:0] bundle_lsb_i;
  logic [HV-1:0] hv_o;
  logic          hv_valid_o;
  logic          hv_ready_i = 1'b0;
  logic          busy_o;
  logic [NW-1:0] items_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int excl_viol = 0;
  logic [HV-1:0] vecs[$];
  logic signed [15:0] cnt [HV];

  bundler_ctrl #(.HVDimension(HV), .NumItemsWidth(NW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .num_items_i(num_items_i),
    .abort_i(abort_i), .hv_i(hv_i), .hv_valid_i(hv_valid_i), .hv_ready_o(hv_ready_o),
    .bundle_bits_o(bundle_bits_o), .bundle_valid_o(bundle_valid_o),
    .bundle_clr_o(bundle_clr_o), .bundle_binarize_o(bundle_binarize_o),
    .bundle_lsb_i(bundle_lsb_i), .hv_o(hv_o), .hv_valid_o(hv_valid_o),
    .hv_ready_i(hv_ready_i), .busy_o(busy_o), .items_o(items_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // bundler bank: up/down counters, clear has priority, ties binarize to 1; not cleared by rst
  always @(posedge clk) begin
    for (int i = 0; i < HV; i++) begin
      if (bundle_clr_o) cnt[i] <= 16'sd0;
      else if (bundle_binarize_o) cnt[i] <= (cnt[i] >= 0) ? 16'sd1 : 16'sd0;
      else if (bundle_valid_o) cnt[i] <= bundle_bits_o[i] ? cnt[i] + 16'sd1 : cnt[i] - 16'sd1;
    end
  end

  always_comb begin
    bundle_lsb_i = '0;
    for (int i = 0; i < HV; i++) bundle_lsb_i[i] = cnt[i][0];
  end

  // strobe monitor
  always @(posedge clk) begin
    if (bundle_clr_o) clr_cnt <= clr_cnt + 1;
    if (32'(bundle_clr_o) + 32'(bundle_valid_o) + 32'(bundle_binarize_o) > 1)
      excl_viol <= excl_viol + 1;
  end

  function automatic logic [HV-1:0] majority(input int n);
    logic [HV-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < HV; b++) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(vecs[k][b]);
      r[b] = (2 * ones >= n);
    end
    return r;
  endfunction

  function automatic logic [HV-1:0] rand_hv();
    logic [HV-1:0] r;
    for (int w = 0; w < HV / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic expect_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({hv_valid_o, hv_ready_o, bundle_valid_o, bundle_clr_o, bundle_binarize_o, err_o, busy_o} !== 7'b0
        || hv_o !== '0 || items_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: strobes=%b items=%0d hv_o_nonzero=%b expected all zero",
               {hv_valid_o, hv_ready_o, bundle_valid_o, bundle_clr_o, bundle_binarize_o, err_o, busy_o},
               items_o, |hv_o);
    end
    rst = 1'b0;
  endtask

  task automatic run_job(input int n, input int gap_pct, input int stall_pct);
    logic [HV-1:0] exp_hv, held;
    int idx, cyc, c0;
    exp_hv = majority(n);
    @(negedge clk);
    c0 = clr_cnt;
    start_i = 1'b1;
    num_items_i = NW'(n);
    hv_valid_i = 1'b0;
    #1;
    expect_bit("start_clr", bundle_clr_o, 1'b1);
    expect_bit("start_err", err_o, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      hv_valid_i = ($urandom_range(99) >= 32'(gap_pct)) || (cyc > 1000);
      hv_i = vecs[idx];
      #1;
      checks++;
      if (hv_ready_o !== 1'b1 || busy_o !== 1'b1 || bundle_valid_o !== hv_valid_i
          || bundle_clr_o !== 1'b0 || items_o !== NW'(idx) || bundle_bits_o !== hv_i) begin
        errors++;
        $display("FAIL accum: ready=%b busy=%b bvalid=%b clr=%b items=%0d expected ready=1 busy=1 bvalid=%b clr=0 items=%0d",
                 hv_ready_o, busy_o, bundle_valid_o, bundle_clr_o, items_o, hv_valid_i, idx);
      end
      if (hv_valid_i) idx++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) begin
      checks++;
      errors++;
      $display("FAIL accum_timeout: accepted %0d expected %0d", idx, n);
    end
    hv_valid_i = 1'b0;
    #1;
    checks++;
    if (bundle_binarize_o !== 1'b1 || hv_ready_o !== 1'b0 || items_o !== NW'(n)) begin
      errors++;
      $display("FAIL binarize: bin=%b ready=%b items=%0d expected bin=1 ready=0 items=%0d",
               bundle_binarize_o, hv_ready_o, items_o, n);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bundle_binarize_o !== 1'b0 || hv_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL capture: bin=%b hv_valid=%b expected 0 0", bundle_binarize_o, hv_valid_o);
    end
    @(negedge clk);
    #1;
    expect_bit("result_valid", hv_valid_o, 1'b1);
    checks++;
    if (hv_o !== exp_hv) begin
      errors++;
      $display("FAIL result: got %h expected %h", hv_o, exp_hv);
    end
    held = hv_o;
    cyc = 0;
    forever begin
      hv_ready_i = (cyc >= 50) || ($urandom_range(99) >= 32'(stall_pct));
      #1;
      checks++;
      if (hv_valid_o !== 1'b1 || hv_o !== held || bundle_clr_o !== hv_ready_i) begin
        errors++;
        $display("FAIL output_hold: valid=%b stable=%b clr=%b expected valid=1 stable=1 clr=%b",
                 hv_valid_o, hv_o === held, bundle_clr_o, hv_ready_i);
      end
      if (hv_ready_i) break;
      cyc++;
      @(negedge clk);
    end
    @(negedge clk);
    hv_ready_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || hv_valid_o !== 1'b0 || clr_cnt - c0 != 2) begin
      errors++;
      $display("FAIL job_end: busy=%b valid=%b clears=%0d expected busy=0 valid=0 clears=2",
               busy_o, hv_valid_o, clr_cnt - c0);
    end
  endtask

  task automatic test_majority();
    vecs.delete();
    vecs.push_back({{(HV-4){1'b0}}, 4'b1100});
    vecs.push_back({{(HV-4){1'b0}}, 4'b1010});
    vecs.push_back({{(HV-4){1'b0}}, 4'b1001});
    run_job(3, 0, 0);
    checks++;
    if (hv_o[3:0] !== 4'b1000) begin
      errors++;
      $display("FAIL majority3: got %b expected 1000", hv_o[3:0]);
    end
  endtask

  task automatic test_tie();
    vecs.delete();
    vecs.push_back({{(HV-4){1'b0}}, 4'b1010});
    vecs.push_back({{(HV-4){1'b0}}, 4'b0101});
    run_job(2, 0, 0);
    checks++;
    if (hv_o[3:0] !== 4'b1111) begin
      errors++;
      $display("FAIL tie: got %b expected 1111", hv_o[3:0]);
    end
  endtask

  task automatic test_zero_length();
    @(negedge clk);
    start_i = 1'b1;
    num_items_i = '0;
    #1;
    expect_bit("zero_err", err_o, 1'b1);
    expect_bit("zero_clr", bundle_clr_o, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    expect_bit("zero_err_pulse", err_o, 1'b0);
    expect_bit("zero_busy", busy_o, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    start_i = 1'b1;
    num_items_i = NW'(5);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hv_i = rand_hv();
      hv_valid_i = 1'b1;
      @(negedge clk);
    end
    abort_i = 1'b1;
    #1;
    expect_bit("abort_clr", bundle_clr_o, 1'b1);
    expect_bit("abort_no_acc", bundle_valid_o, 1'b0);
    expect_bit("abort_ready", hv_ready_o, 1'b0);
    @(negedge clk);
    abort_i = 1'b0;
    hv_valid_i = 1'b0;
    #1;
    expect_bit("abort_idle", busy_o, 1'b0);
    vecs.delete();
    vecs.push_back('0);
    run_job(1, 0, 0);
    checks++;
    if (hv_o !== '0) begin
      errors++;
      $display("FAIL abort_followup: got %h expected 0", hv_o);
    end
  endtask

  task automatic test_reset_mid_job();
    vecs.delete();
    @(negedge clk);
    start_i = 1'b1;
    num_items_i = NW'(2);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hv_i = rand_hv();
      hv_valid_i = 1'b1;
      @(negedge clk);
    end
    hv_valid_i = 1'b0;
    #1;
    expect_bit("pre_reset_binarize", bundle_binarize_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({hv_valid_o, hv_ready_o, bundle_valid_o, bundle_clr_o, bundle_binarize_o, err_o, busy_o} !== 7'b0
        || hv_o !== '0 || items_o !== '0) begin
      errors++;
      $display("FAIL midjob_reset: strobes=%b items=%0d expected all zero",
               {hv_valid_o, hv_ready_o, bundle_valid_o, bundle_clr_o, bundle_binarize_o, err_o, busy_o}, items_o);
    end
    for (int k = 0; k < 3; k++) vecs.push_back(rand_hv());
    run_job(3, 30, 30);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      int n;
      n = $urandom_range(12, 1);
      vecs.delete();
      for (int k = 0; k < n; k++) vecs.push_back(rand_hv());
      run_job(n, 40, 50);
    end
  endtask

  task automatic test_exclusion();
    checks++;
    if (excl_viol != 0) begin
      errors++;
      $display("FAIL strobe_exclusion: %0d overlapping cycles expected 0", excl_viol);
    end
  endtask

  initial begin
    for (int i = 0; i < HV; i++) cnt[i] = 16'sd0;
    test_reset();
    test_majority();
    test_tie();
    test_zero_length();
    test_abort();
    test_reset_mid_job();
    test_back_to_back();
    test_exclusion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
